// File: rtl/clm_aes_core_arbiter_pkg.sv
// Shared types and widths for the CLM AES core arbiter and its helpers.
package clm_aes_core_arbiter_pkg;

    localparam int DATA_W  = 128;
    localparam int P_DET_W = 2;

    typedef logic [P_DET_W-1:0] p_det_t;

    localparam p_det_t P_DET_DEFAULT = 2'd0;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_BUSY,
        ARB_ABORT,
        ARB_RESPOND
    } arb_state_t;

endpackage

// File: rtl/clm_aes_core_arbiter_rr_grant.sv
// Combinational round-robin picker: first valid requester at or after ptr.
module rr_grant #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [IDX_W-1:0] ptr,
    input  logic [N_REQ-1:0] valid,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        int pos;
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = 0;
        // Scan from farthest to nearest so the requester closest to ptr wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            pos = (int'(ptr) + k) % N_REQ;
            if (valid[pos]) begin
                grant      = '0;
                grant[pos] = 1'b1;
                idx        = IDX_W'(pos);
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/clm_aes_core_arbiter.sv
// Round-robin sharing of one CLM AES core among N_REQ requesters, with
// operand latching, done/response sequencing and a hang watchdog.
module clm_aes_core_arbiter
    import clm_aes_core_arbiter_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 1024,
    parameter int IDX_W   = $clog2(N_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*DATA_W-1:0]    req_plaintext,
    input  logic [N_REQ*DATA_W-1:0]    req_key,
    input  logic [N_REQ*P_DET_W-1:0]   req_p_det,
    output logic [N_REQ-1:0]           resp_valid,
    input  logic [N_REQ-1:0]           resp_ready,
    output logic [DATA_W-1:0]          resp_ciphertext,
    output logic                       resp_err,
    output logic                       core_drdy_i,
    input  logic                       core_drdy_o,
    output logic [DATA_W-1:0]          core_plaintext,
    output logic [DATA_W-1:0]          core_key,
    output logic [P_DET_W-1:0]         core_p_det,
    input  logic [DATA_W-1:0]          core_ciphertext,
    output logic                       core_rst,
    output logic                       busy,
    output logic [IDX_W-1:0]           owner
);

    localparam int CNT_W = $clog2(TIMEOUT);

    arb_state_t       state, state_nxt;
    logic [IDX_W-1:0] ptr;
    logic [CNT_W-1:0] cnt;
    logic [N_REQ-1:0] grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_any;
    logic             timeout_hit;
    logic             resp_done;

    rr_grant #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr_grant (
        .ptr   (ptr),
        .valid (req_valid),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
    assign resp_done   = resp_ready[owner];
    assign busy        = (state != ARB_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= ARB_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        req_ready   = '0;
        resp_valid  = '0;
        core_drdy_i = 1'b0;
        core_rst    = rst;
        case (state)
            ARB_IDLE: begin
                req_ready = grant;
                if (grant_any) state_nxt = ARB_ISSUE;
            end
            ARB_ISSUE: begin
                core_drdy_i = 1'b1;
                state_nxt   = ARB_BUSY;
            end
            ARB_BUSY: begin
                // A done pulse on the last allowed cycle still beats the watchdog.
                if (core_drdy_o)      state_nxt = ARB_RESPOND;
                else if (timeout_hit) state_nxt = ARB_ABORT;
            end
            ARB_ABORT: begin
                core_rst  = 1'b1;
                state_nxt = ARB_RESPOND;
            end
            ARB_RESPOND: begin
                resp_valid[owner] = 1'b1;
                if (resp_done) state_nxt = ARB_IDLE;
            end
            default: state_nxt = ARB_IDLE;
        endcase
        // Reset suppresses handshakes and keeps the start pulse off the core reset.
        if (rst) begin
            req_ready   = '0;
            resp_valid  = '0;
            core_drdy_i = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr             <= '0;
            owner           <= '0;
            cnt             <= '0;
            core_plaintext  <= '0;
            core_key        <= '0;
            core_p_det      <= '0;
            resp_ciphertext <= '0;
            resp_err        <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (grant_any) begin
                        owner          <= grant_idx;
                        core_plaintext <= req_plaintext[grant_idx*DATA_W +: DATA_W];
                        core_key       <= req_key[grant_idx*DATA_W +: DATA_W];
                        core_p_det     <= req_p_det[grant_idx*P_DET_W +: P_DET_W];
                    end
                end
                ARB_ISSUE: cnt <= '0;
                ARB_BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (core_drdy_o) begin
                        resp_ciphertext <= core_ciphertext;
                        resp_err        <= 1'b0;
                    end
                end
                ARB_ABORT: begin
                    resp_ciphertext <= '0;
                    resp_err        <= 1'b1;
                end
                ARB_RESPOND: begin
                    if (resp_done)
                        ptr <= (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_clm_aes_core_arbiter.sv
// Randomized bench for clm_aes_core_arbiter: a behavioural core responder
// plus a round-robin/latency reference model computed from first principles.
module tb_clm_aes_core_arbiter;
    import clm_aes_core_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int T  = 48;
    localparam int IW = 2;
    localparam int W  = DATA_W;
    localparam int PW = P_DET_W;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] FIPS_CT  = 128'h3925841d02dc09fbdc118597196a0b32;

    logic            clk, rst;
    logic [N-1:0]    req_valid, req_ready, resp_valid, resp_ready;
    logic [N*W-1:0]  req_plaintext, req_key;
    logic [N*PW-1:0] req_p_det;
    logic [W-1:0]    resp_ciphertext, core_plaintext, core_key, core_ciphertext;
    logic            resp_err, core_drdy_i, core_drdy_o, core_rst, busy;
    logic [PW-1:0]   core_p_det;
    logic [IW-1:0]   owner;

    clm_aes_core_arbiter #(.N_REQ(N), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_plaintext(req_plaintext), .req_key(req_key), .req_p_det(req_p_det),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_ciphertext(resp_ciphertext), .resp_err(resp_err),
        .core_drdy_i(core_drdy_i), .core_drdy_o(core_drdy_o),
        .core_plaintext(core_plaintext), .core_key(core_key), .core_p_det(core_p_det),
        .core_ciphertext(core_ciphertext), .core_rst(core_rst),
        .busy(busy), .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [127:0] pt_a [N];
    logic [127:0] key_a[N];
    logic [PW-1:0] pd_a[N];

    int           m_ptr = 0;
    int           lat_g;
    logic [127:0] lat_pt, lat_key, exp_ct;
    logic [PW-1:0] lat_pd;

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Stand-in for the AES core: the FIPS-197 vector maps to its known answer,
    // anything else to a cheap mix of the operands.
    function automatic logic [127:0] model_core(logic [127:0] pt, logic [127:0] key, logic [PW-1:0] pd);
        if (pt == FIPS_PT && key == FIPS_KEY && pd == P_DET_DEFAULT) return FIPS_CT;
        return pt ^ {key[63:0], key[127:64]} ^ {{(128-PW){1'b0}}, pd};
    endfunction

    function automatic int model_grant(logic [N-1:0] v, int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic drive_ops();
        for (int i = 0; i < N; i++) begin
            req_plaintext[i*W +: W] = pt_a[i];
            req_key[i*W +: W]       = key_a[i];
            req_p_det[i*PW +: PW]   = pd_a[i];
        end
    endtask

    task automatic scramble_ops();
        for (int i = 0; i < N; i++) begin
            pt_a[i]  = rand128();
            key_a[i] = rand128();
            pd_a[i]  = PW'($urandom_range(0, 3));
        end
        drive_ops();
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Caller has set req_valid/operands just after an edge; checks the grant
    // this cycle and the start pulse plus latched operands the next cycle.
    task automatic start_job();
        logic [N-1:0] exp_rdy;
        drive_ops();
        @(negedge clk);
        lat_g   = model_grant(req_valid, m_ptr);
        exp_rdy = '0;
        if (lat_g >= 0) exp_rdy[lat_g] = 1'b1;
        checks++;
        if (req_ready !== exp_rdy) begin
            failures++;
            $display("FAIL grant: req_ready=%b expected %b", req_ready, exp_rdy);
        end
        if (lat_g < 0) return;
        lat_pt  = pt_a[lat_g];
        lat_key = key_a[lat_g];
        lat_pd  = pd_a[lat_g];
        exp_ct  = model_core(lat_pt, lat_key, lat_pd);
        cyc();
        scramble_ops();
        @(negedge clk);
        checks++;
        if ({core_drdy_i, owner, core_plaintext, core_key, core_p_det, req_ready} !==
            {1'b1, IW'(lat_g), lat_pt, lat_key, lat_pd, {N{1'b0}}}) begin
            failures++;
            $display("FAIL issue: drdy_i=%b owner=%0d pt=%h expected drdy_i=1 owner=%0d pt=%h",
                     core_drdy_i, owner, core_plaintext, lat_g, lat_pt);
        end
    endtask

    // Runs the job from BUSY to release. d = cycle (counted from the accept
    // cycle) of the core done pulse, or -1 for a core that never answers.
    task automatic finish_job(input int d, input int bp);
        bit           abort;
        int           r;
        logic [N-1:0] exp_rv, rr;
        logic [127:0] exp_resp;
        abort    = (d < 0);
        r        = abort ? T + 3 : d + 1;
        exp_resp = abort ? '0 : exp_ct;
        exp_rv   = '0;
        exp_rv[lat_g] = 1'b1;
        for (int c = 2; c < r; c++) begin
            cyc();
            core_drdy_o     = !abort && (c == d);
            core_ciphertext = (c == d) ? exp_ct : rand128();
            scramble_ops();
            @(negedge clk);
            checks++;
            if ({core_drdy_i, resp_valid, core_rst, core_plaintext, core_key, core_p_det, busy} !==
                {1'b0, {N{1'b0}}, (abort && c == T + 2), lat_pt, lat_key, lat_pd, 1'b1}) begin
                failures++;
                $display("FAIL busy c=%0d: drdy_i=%b rv=%b core_rst=%b pt=%h expected rst=%b pt=%h",
                         c, core_drdy_i, resp_valid, core_rst, core_plaintext,
                         (abort && c == T + 2), lat_pt);
            end
        end
        cyc();
        core_drdy_o     = 1'b0;
        core_ciphertext = rand128();
        @(negedge clk);
        checks++;
        if ({resp_valid, resp_ciphertext, resp_err, core_rst} !== {exp_rv, exp_resp, abort, 1'b0}) begin
            failures++;
            $display("FAIL respond: rv=%b ct=%h err=%b core_rst=%b expected rv=%b ct=%h err=%b",
                     resp_valid, resp_ciphertext, resp_err, core_rst, exp_rv, exp_resp, abort);
        end
        for (int k = 0; k < bp; k++) begin
            cyc();
            rr = N'($urandom);
            rr[lat_g] = 1'b0;
            resp_ready  = rr;
            core_drdy_o = 1'($urandom);
            core_ciphertext = rand128();
            @(negedge clk);
            checks++;
            if ({resp_valid, resp_ciphertext, resp_err, req_ready, core_plaintext, core_drdy_i} !==
                {exp_rv, exp_resp, abort, {N{1'b0}}, lat_pt, 1'b0}) begin
                failures++;
                $display("FAIL hold k=%0d: rv=%b ct=%h err=%b ready=%b expected rv=%b ct=%h",
                         k, resp_valid, resp_ciphertext, resp_err, req_ready, exp_rv, exp_resp);
            end
        end
        cyc();
        resp_ready  = N'($urandom) | exp_rv;
        core_drdy_o = 1'b0;
        @(negedge clk);
        checks++;
        if (resp_valid !== exp_rv) begin
            failures++;
            $display("FAIL release: rv=%b expected %b", resp_valid, exp_rv);
        end
        cyc();
        resp_ready = '0;
        m_ptr = (lat_g + 1) % N;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '1;
        cyc();
        cyc();
        @(negedge clk);
        checks++;
        if ({req_ready, resp_valid, busy, owner, core_drdy_i, core_rst, core_plaintext, resp_ciphertext, resp_err} !==
            {{N{1'b0}}, {N{1'b0}}, 1'b0, {IW{1'b0}}, 1'b0, 1'b1, 128'h0, 128'h0, 1'b0}) begin
            failures++;
            $display("FAIL reset: ready=%b rv=%b busy=%b owner=%0d drdy_i=%b core_rst=%b expected core_rst=1 others 0",
                     req_ready, resp_valid, busy, owner, core_drdy_i, core_rst);
        end
        cyc();
        rst = 1'b0;
        req_valid = '0;
        @(negedge clk);
        checks++;
        if ({core_rst, busy} !== 2'b00) begin
            failures++;
            $display("FAIL reset_release: core_rst=%b busy=%b expected 0 0", core_rst, busy);
        end
        cyc();
        m_ptr = 0;
    endtask

    task automatic test_round_robin();
        int exp_order[5] = '{0, 1, 2, 3, 0};
        req_valid = '1;
        scramble_ops();
        for (int j = 0; j < 5; j++) begin
            start_job();
            checks++;
            if (int'(owner) !== exp_order[j]) begin
                failures++;
                $display("FAIL rr_order j=%0d: owner=%0d expected %0d", j, owner, exp_order[j]);
            end
            finish_job($urandom_range(2, T + 1), $urandom_range(0, 2));
        end
        req_valid = '0;
    endtask

    task automatic test_single_job();
        req_valid = 4'b0100;
        scramble_ops();
        pt_a[2]  = FIPS_PT;
        key_a[2] = FIPS_KEY;
        pd_a[2]  = P_DET_DEFAULT;
        start_job();
        finish_job(40, 0);
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        req_valid = N'($urandom_range(1, 15));
        scramble_ops();
        start_job();
        finish_job($urandom_range(2, 20), 10);
        req_valid = '0;
    endtask

    task automatic test_timeout();
        req_valid = N'($urandom_range(1, 15));
        scramble_ops();
        start_job();
        finish_job(-1, 2);
        req_valid = N'($urandom_range(1, 15));
        scramble_ops();
        start_job();
        finish_job($urandom_range(2, T + 1), 1);
        req_valid = '0;
    endtask

    task automatic test_race();
        req_valid = N'($urandom_range(1, 15));
        scramble_ops();
        start_job();
        finish_job(T + 1, 0);
        req_valid = '0;
    endtask

    task automatic test_back_to_back();
        req_valid = 4'b1000;
        scramble_ops();
        for (int j = 0; j < 2; j++) begin
            start_job();
            finish_job($urandom_range(2, 6), 0);
        end
        req_valid = '0;
    endtask

    task automatic test_random_jobs();
        for (int j = 0; j < 6; j++) begin
            req_valid = N'($urandom_range(1, 15));
            scramble_ops();
            start_job();
            if ($urandom_range(0, 5) == 0) finish_job(-1, $urandom_range(0, 3));
            else finish_job($urandom_range(2, T + 1), $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) req_valid = '0;
        end
        req_valid = '0;
        cyc();
    endtask

    task automatic test_reset_mid_busy();
        req_valid = 4'b0001;
        scramble_ops();
        start_job();
        finish_job(5, 0);
        req_valid = 4'b0100;
        scramble_ops();
        start_job();
        for (int c = 0; c < 3; c++) cyc();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({core_rst, core_drdy_i, req_ready, resp_valid} !== {1'b1, 1'b0, {N{1'b0}}, {N{1'b0}}}) begin
            failures++;
            $display("FAIL mid_reset: core_rst=%b drdy_i=%b ready=%b rv=%b expected 1 0 0 0",
                     core_rst, core_drdy_i, req_ready, resp_valid);
        end
        cyc();
        rst = 1'b0;
        req_valid = '0;
        m_ptr = 0;
        @(negedge clk);
        checks++;
        if ({busy, owner, resp_valid, core_plaintext, core_key, core_rst, resp_err, resp_ciphertext} !==
            {1'b0, {IW{1'b0}}, {N{1'b0}}, 128'h0, 128'h0, 1'b0, 1'b0, 128'h0}) begin
            failures++;
            $display("FAIL after_reset: busy=%b owner=%0d rv=%b pt=%h core_rst=%b expected all 0",
                     busy, owner, resp_valid, core_plaintext, core_rst);
        end
        cyc();
        core_drdy_o     = 1'b1;
        core_ciphertext = rand128();
        cyc();
        core_drdy_o = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, resp_valid, resp_ciphertext} !== {1'b0, {N{1'b0}}, 128'h0}) begin
            failures++;
            $display("FAIL spurious_done: busy=%b rv=%b ct=%h expected 0 0 0", busy, resp_valid, resp_ciphertext);
        end
        cyc();
        req_valid = '1;
        scramble_ops();
        start_job();
        finish_job($urandom_range(2, 10), 0);
        req_valid = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        req_valid = '0;
        resp_ready = '0;
        core_drdy_o = 1'b0;
        core_ciphertext = '0;
        for (int i = 0; i < N; i++) begin
            pt_a[i] = '0;
            key_a[i] = '0;
            pd_a[i] = '0;
        end
        drive_ops();
        test_reset();
        test_round_robin();
        test_single_job();
        test_backpressure();
        test_timeout();
        test_race();
        test_back_to_back();
        test_random_jobs();
        test_reset_mid_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clm_aes_core_arbiter.md
Name: clm_aes_core_arbiter

Overview:
- Shares one CLM AES encryption core among N_REQ independent requesters.
- Requesters are served round-robin. Each job's plaintext, key and p_det are latched and held stable for the whole encryption.
- Sequences the core's drdy_i/drdy_o handshake and returns the ciphertext with backpressure.
- A watchdog pulses a core-local reset and returns an error response if the core hangs.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT, 1024, maximum BUSY cycles before abort (>= 4).
- IDX_W, $clog2(N_REQ), requester index width (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Synchronous, active-high.
- req_valid  in  N_REQ  request present, one bit per requester.
- req_ready  out  N_REQ  request accepted this cycle.
- req_plaintext  in  N_REQ x 128  plaintext per requester.
- req_key  in  N_REQ x 128  key per requester.
- req_p_det  in  N_REQ x p_det_t  modulus selector per requester.
- resp_valid  out  N_REQ  response present for the owning requester.
- resp_ready  in  N_REQ  requester consumes the response.
- resp_ciphertext  out  128  shared result bus, valid with resp_valid.
- resp_err  out  1  response is a timeout abort.
- core_drdy_i  out  1  start pulse to the core.
- core_drdy_o  in  1  core done pulse.
- core_plaintext  out  128  latched plaintext to the core.
- core_key  out  128  latched key to the core.
- core_p_det  out  p_det_t  latched p_det to the core.
- core_ciphertext  in  128  core result.
- core_rst  out  1  core reset. Equals rst OR abort pulse.
- busy  out  1  state != IDLE.
- owner  out  IDX_W  index of the current job.

Behaviour:
- Reset (rst=1 at posedge) drives the following:
  - state=IDLE; ptr=0; owner=0; cnt=0.
  - All operand and ciphertext registers = 0; resp_err=0.
  - All outputs 0 except core_rst=1.
  - rst asserted in any state aborts the job silently. No response is produced.
- Grant (combinational, IDLE only):
  - g = first i with req_valid[i], scanning ptr, ptr+1, ... mod N_REQ.
  - req_ready is one-hot at g; it is all-zero outside IDLE or when no request is valid.
- States:
  - IDLE: on req_valid[g], latch operands[g] and set owner=g; go to ISSUE.
  - ISSUE (1 cycle): core_drdy_i=1; cnt=0; go to BUSY.
  - BUSY: cnt increments each cycle.
    - core_drdy_o=1: capture core_ciphertext, resp_err=0, go to RESPOND.
    - Otherwise, if cnt==TIMEOUT-1: go to ABORT.
    - If core_drdy_o coincides with cnt==TIMEOUT-1, done wins: no abort.
  - ABORT (1 cycle): core_rst=1; ciphertext register=0; resp_err=1; go to RESPOND.
  - RESPOND: resp_valid[owner]=1, other bits 0. Hold until resp_ready[owner].
    - Then ptr=(owner+1) mod N_REQ; go to IDLE.
    - resp_ready on non-owner bits is ignored.
- Latency:
  - Handshake at cycle t gives core_drdy_i at t+1.
  - core_drdy_o at cycle u gives resp_valid at u+1.
  - Earliest next accept is the cycle after the resp handshake.
- Stability: core_plaintext, core_key and core_p_det are constant from ISSUE through RESPOND. The core reads p_det combinationally during SUB_BYTES.
- core_drdy_o outside BUSY is ignored.
- core_drdy_i is high only in ISSUE. It never coincides with core_rst.
- Wrap-around: ptr at N_REQ-1 wraps to 0. A single requester that is continuously valid is served back-to-back.

Decomposition:
- Package types gains arb_state_t: enum {ARB_IDLE, ARB_ISSUE, ARB_BUSY, ARB_ABORT, ARB_RESPOND}.
- Sub-module rr_grant (ptr, valid -> one-hot grant + index). Purely combinational; reused by later schedulers.

Test Plan:
1. Single job: req_valid=4'b0100 at t; FIPS-197 key/plaintext, p_det=P_DET_DEFAULT, core model done at t+40.
   - Expect req_ready=4'b0100 at t and core_drdy_i at t+1.
   - Expect resp_valid=4'b0100 at t+41 with ciphertext 3925841d02dc09fbdc118597196a0b32 and resp_err=0.
2. Round-robin: all four valid continuously.
   - Grant order 0,1,2,3,0.
   - Core operands change only in IDLE/ISSUE; each response goes to the matching owner.
3. Backpressure: resp_ready held 0 for 10 cycles.
   - resp_valid and ciphertext held stable; no new req_ready until release; ptr advances after release.
4. Timeout: TIMEOUT=8, core never responds.
   - ABORT 8 cycles after entering BUSY, with core_rst=1 for exactly 1 cycle.
   - Then resp_err=1 and ciphertext 0; the next job completes normally.
5. Race: core_drdy_o at cnt==TIMEOUT-1.
   - Normal response, resp_err=0, no core_rst pulse.
6. Reset mid-BUSY: rst for 1 cycle.
   - All outputs reset values, no resp_valid; spurious core_drdy_o afterwards ignored; ptr=0.
